// File: rtl/change_dispense_ctrl.sv
// rtl/change_dispense_ctrl.sv - greedy change-return sequencer driving a one-note-per-handshake dispenser
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   start, change_amount        begin returning change_amount (sampled in IDLE)
//   refill                      reload every denomination counter (IDLE only)
//   dispense_ack                actuator accepted the current note
//   dispense_req, dispense_denom   note request and its one-hot {50,20,10,5,1}
//   remaining, inventory        amount still owed, packed counters {c50,c20,c10,c5,c1}
//   busy, done, fail, fail_code status; fail_code 01 = empty inventory, 10 = ack timeout
//   state_out                   one-hot state
module change_dispense_ctrl #(
   parameter int INIT_CNT    = 8,
   parameter int CNT_W       = 4,
   parameter int GAP_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 1000
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               start,
   input  logic [7:0]         change_amount,
   input  logic               refill,
   input  logic               dispense_ack,
   output logic               dispense_req,
   output logic [4:0]         dispense_denom,
   output logic [7:0]         remaining,
   output logic [5*CNT_W-1:0] inventory,
   output logic               busy,
   output logic               done,
   output logic               fail,
   output logic [1:0]         fail_code,
   output logic [6:0]         state_out
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_CNT);

   // Index 0 is the smallest note; bit i of a one-hot denom selects DVAL[i].
   localparam logic [7:0] DVAL [5] = '{8'd1, 8'd5, 8'd10, 8'd20, 8'd50};

   typedef enum logic [6:0] {
      S_IDLE   = 7'h01,
      S_SELECT = 7'h02,
      S_REQ    = 7'h04,
      S_WAIT   = 7'h08,
      S_GAP    = 7'h10,
      S_DONE   = 7'h20,
      S_FAIL   = 7'h40
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt [5];
   logic [4:0]       denom;
   logic [4:0]       pick;
   logic [7:0]       sel_val;
   logic [TMR_W-1:0] tmr;
   logic [GAP_W-1:0] gap;

   // Greedy choice: largest note that still fits the remainder and is in stock.
   always_comb begin
      pick = '0;
      for (int i = 4; i >= 0; i--) begin
         if (pick == '0 && remaining >= DVAL[i] && cnt[i] != '0) begin
            pick[i] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_val = '0;
      for (int i = 0; i < 5; i++) begin
         if (denom[i]) begin
            sel_val = sel_val | DVAL[i];
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_SELECT;
         S_SELECT: begin
            if (remaining == '0) begin
               state_nxt = S_DONE;
            end else if (pick != '0) begin
               state_nxt = S_REQ;
            end else begin
               state_nxt = S_FAIL;
            end
         end
         S_REQ:    state_nxt = S_WAIT;
         // An ack on the final timeout cycle still wins.
         S_WAIT: begin
            if (dispense_ack) begin
               state_nxt = S_GAP;
            end else if (tmr == TMR_LAST) begin
               state_nxt = S_FAIL;
            end
         end
         S_GAP:    if (gap == GAP_LAST) state_nxt = S_SELECT;
         S_DONE:   state_nxt = S_IDLE;
         S_FAIL:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         remaining <= '0;
         denom     <= '0;
         fail_code <= '0;
         tmr       <= '0;
         gap       <= '0;
         for (int i = 0; i < 5; i++) begin
            cnt[i] <= INIT_VAL;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (refill) begin
                  for (int i = 0; i < 5; i++) begin
                     cnt[i] <= INIT_VAL;
                  end
               end
               if (start) begin
                  remaining <= change_amount;
                  fail_code <= 2'b00;
               end
            end
            S_SELECT: begin
               if (remaining != '0) begin
                  if (pick != '0) begin
                     denom <= pick;
                  end else begin
                     fail_code <= 2'b01;
                  end
               end
            end
            S_REQ: tmr <= '0;
            S_WAIT: begin
               if (dispense_ack) begin
                  remaining <= remaining - sel_val;
                  for (int i = 0; i < 5; i++) begin
                     if (denom[i]) begin
                        cnt[i] <= cnt[i] - 1'b1;
                     end
                  end
                  gap <= '0;
               end else if (tmr == TMR_LAST) begin
                  fail_code <= 2'b10;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            S_GAP: gap <= gap + 1'b1;
            default: ;
         endcase
      end
   end

   // Decoded from the state register so a reset drops the request immediately.
   assign dispense_req   = (state == S_REQ) || (state == S_WAIT);
   assign dispense_denom = dispense_req ? denom : 5'b00000;
   assign busy           = (state != S_IDLE);
   assign done           = (state == S_DONE);
   assign fail           = (state == S_FAIL);
   assign state_out      = state;

   always_comb begin
      inventory = '0;
      for (int i = 0; i < 5; i++) begin
         inventory[i*CNT_W +: CNT_W] = cnt[i];
      end
   end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb/tb_change_dispense_ctrl.sv - scoreboard bench for change_dispense_ctrl
module tb_change_dispense_ctrl;

   localparam int INIT_CNT    = 8;
   localparam int CNT_W       = 4;
   localparam int GAP_CYCLES  = 4;
   localparam int ACK_TIMEOUT = 16;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [7:0]   change_amount;
   logic         refill;
   logic         ack;
   logic         dispense_req;
   logic [4:0]   dispense_denom;
   logic [7:0]   remaining;
   logic [19:0]  inventory;
   logic         busy;
   logic         done;
   logic         fail;
   logic [1:0]   fail_code;
   logic [6:0]   state_out;

   change_dispense_ctrl #(
      .INIT_CNT    (INIT_CNT),
      .CNT_W       (CNT_W),
      .GAP_CYCLES  (GAP_CYCLES),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .sys_clk        (clk),
      .sys_rst_n      (rst_n),
      .start          (start),
      .change_amount  (change_amount),
      .refill         (refill),
      .dispense_ack   (ack),
      .dispense_req   (dispense_req),
      .dispense_denom (dispense_denom),
      .remaining      (remaining),
      .inventory      (inventory),
      .busy           (busy),
      .done           (done),
      .fail           (fail),
      .fail_code      (fail_code),
      .state_out      (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind: 0 note request, 1 done, 2 fail
   // timing: 0 = 2 cycles after start, 1 = GAP+2 after last ack, 2 = timeout after request
   typedef struct {
      int         kind;
      logic [4:0] denom;
      logic [1:0] code;
      logic [7:0] rem;
      logic [19:0] inv;
      int         timing;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;
   int  inv_m[5];
   int  dval[5] = '{1, 5, 10, 20, 50};

   int   cyc       = 0;
   int   start_cyc = 0;
   int   ack_cyc   = 0;
   int   req_cyc   = 0;
   int   wait_cnt  = 0;
   logic [4:0] held_denom = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] pack_inv();
      logic [19:0] p;
      p = '0;
      for (int i = 0; i < 5; i++) p[i*4 +: 4] = inv_m[i][3:0];
      return p;
   endfunction

   task automatic push_ev(input int kind, input int idx, input logic [1:0] code, input int rem, input int timing);
      ev_t e;
      e.kind  = kind;
      e.denom = '0;
      if (kind == 0) e.denom[idx] = 1'b1;
      e.code   = code;
      e.rem    = rem[7:0];
      e.inv    = pack_inv();
      e.timing = timing;
      exp_q.push_back(e);
   endtask

   // Reference: pay greedily from the model inventory; note number stall_idx is never acked.
   task automatic model_txn(input int amount, input int stall_idx);
      int rem;
      int note;
      int timing;
      int pk;
      rem    = amount;
      note   = 0;
      timing = 0;
      forever begin
         if (rem == 0) begin
            push_ev(1, 0, 2'b00, 0, timing);
            return;
         end
         pk = -1;
         for (int i = 4; i >= 0; i--) if (pk < 0 && dval[i] <= rem && inv_m[i] > 0) pk = i;
         if (pk < 0) begin
            push_ev(2, 0, 2'b01, rem, timing);
            return;
         end
         note++;
         push_ev(0, pk, 2'b00, rem, timing);
         if (note == stall_idx) begin
            push_ev(2, 0, 2'b10, rem, 2);
            return;
         end
         rem = rem - dval[pk];
         inv_m[pk] = inv_m[pk] - 1;
         timing = 1;
      end
   endtask

   task automatic observe(input int kind);
      ev_t e;
      int  lat;
      int  lat_exp;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_event actual_kind=%0d required=none (t=%0t)", kind, $time);
         return;
      end
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      case (e.timing)
         0:       begin lat = cyc - start_cyc; lat_exp = 2; end
         1:       begin lat = cyc - ack_cyc;   lat_exp = GAP_CYCLES + 2; end
         default: begin lat = cyc - req_cyc;   lat_exp = ACK_TIMEOUT + 1; end
      endcase
      check("event_latency", lat, lat_exp);
      check("event_inventory", inventory, e.inv);
      check("event_remaining", remaining, e.rem);
      if (kind == 0) check("req_denom", dispense_denom, e.denom);
      if (kind == 1) check("done_fail_code", fail_code, 2'b00);
      if (kind == 2) check("fail_code", fail_code, e.code);
      if (kind == 2 && e.code == 2'b10) check("wait_ack_cycles", wait_cnt, ACK_TIMEOUT);
   endtask

   // Monitor: samples on the falling edge; stimulus changes just after the rising edge.
   initial begin
      logic prev_req;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_req = 1'b0;
         end else begin
            if (start && !busy) start_cyc = cyc;
            if (dispense_req && ack) ack_cyc = cyc;
            if (dispense_req && state_out == 7'h08) wait_cnt++;
            if (dispense_req && !prev_req) begin
               req_cyc    = cyc;
               wait_cnt   = 0;
               held_denom = dispense_denom;
               observe(0);
            end else if (dispense_req) begin
               check("denom_stable", dispense_denom, held_denom);
            end
            if (done) observe(1);
            if (fail) observe(2);
            prev_req = dispense_req;
         end
      end
   end

   task automatic set_full();
      for (int i = 0; i < 5; i++) inv_m[i] = INIT_CNT;
   endtask

   // delay 0 = random ack delay per note (1..ACK_TIMEOUT cycles into WAIT_ACK)
   task automatic run_txn(input int amount, input int stall_idx, input int delay, input bit with_refill, input bit poke);
      int   idx;
      int   cd;
      int   n;
      logic pr;
      bit   fin;
      idx = 0; cd = 0; n = 0; pr = 1'b0; fin = 1'b0;
      if (with_refill) set_full();
      model_txn(amount, stall_idx);
      start         = 1'b1;
      change_amount = amount[7:0];
      refill        = with_refill;
      while (!fin && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
         start  = 1'b0;
         refill = 1'b0;
         ack    = 1'b0;
         if (poke && n == 1) begin
            start         = 1'b1;
            refill        = 1'b1;
            change_amount = ~amount[7:0];
         end
         if (dispense_req && !pr) begin
            idx++;
            if (idx == stall_idx) cd = 0;
            else if (delay > 0) cd = delay;
            else cd = $urandom_range(1, ACK_TIMEOUT);
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) ack = 1'b1;
         end
         pr = dispense_req;
         if (done || fail) fin = 1'b1;
      end
      if (!fin) begin
         checks++;
         failures++;
         $display("FAIL txn_timeout actual=no_done_or_fail required=done_or_fail amount=%0d", amount);
      end
      @(posedge clk);
      #1;
      ack = 1'b0;
      check("idle_after_txn", state_out, 7'h01);
      check("busy_after_txn", busy, 1'b0);
   endtask

   task automatic do_refill();
      refill = 1'b1;
      @(posedge clk);
      #1;
      refill = 1'b0;
      set_full();
   endtask

   initial begin
      int amt;
      int st;
      bit wt;
      rst_n = 1'b0;
      start = 1'b0;
      change_amount = '0;
      refill = 1'b0;
      ack = 1'b0;
      set_full();
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", state_out, 7'h01);
      check("rst_busy", busy, 1'b0);
      check("rst_req", dispense_req, 1'b0);
      check("rst_denom", dispense_denom, 5'b0);
      check("rst_remaining", remaining, 8'd0);
      check("rst_done", done, 1'b0);
      check("rst_fail", fail, 1'b0);
      check("rst_fail_code", fail_code, 2'b00);
      check("rst_inventory", inventory, 20'h88888);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_txn(37, 0, 0, 1'b0, 1'b0);
      check("inv_after_37", inventory, 20'h87776);
      run_txn(0, 0, 0, 1'b0, 1'b1);
      check("inv_after_0", inventory, 20'h87776);
      repeat (7) run_txn(20, 0, 3, 1'b0, 1'b0);
      run_txn(40, 0, 0, 1'b0, 1'b1);
      repeat (6) run_txn(1, 0, 1, 1'b0, 1'b0);
      run_txn(3, 0, 0, 1'b0, 1'b0);
      check("fail_code_hold", fail_code, 2'b01);
      check("remaining_hold", remaining, 8'd3);

      do_refill();
      repeat (8) run_txn(5, 0, 2, 1'b0, 1'b0);
      repeat (6) run_txn(1, 0, 2, 1'b0, 1'b0);
      run_txn(3, 0, 0, 1'b0, 1'b0);

      run_txn(50, 1, 0, 1'b1, 1'b0);
      check("timeout_code_hold", fail_code, 2'b10);
      run_txn(77, 2, 0, 1'b0, 1'b1);
      run_txn(26, 0, ACK_TIMEOUT, 1'b1, 1'b0);

      repeat (25) begin
         amt = $urandom_range(0, 255);
         st  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
         wt  = ($urandom_range(0, 3) == 0);
         run_txn(amt, st, 0, wt, $urandom_range(0, 1) == 1);
      end

      // Reset while the actuator is being waited on.
      do_refill();
      model_txn(50, 1);
      start = 1'b1;
      change_amount = 8'd50;
      for (int i = 0; i < 10 && state_out != 7'h08; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      check("reached_wait_ack", state_out, 7'h08);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      set_full();
      #1;
      check("async_rst_req", dispense_req, 1'b0);
      check("async_rst_state", state_out, 7'h01);
      check("async_rst_inventory", inventory, 20'h88888);
      check("async_rst_remaining", remaining, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_txn(37, 0, 0, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
Sequencer for the change-return path of the vending machine. It accepts a change amount when the transaction FSM enters change, then drives a dispenser actuator one note per handshake, choosing greedily (50/20/10/5/1) from a per-denomination inventory. It tracks the remaining amount and inventory, and flags failure on an empty inventory or a stuck actuator.

Parameters:
INIT_CNT, 8, notes loaded into each denomination on reset/refill (must fit CNT_W)
CNT_W, 4, width of each inventory counter
GAP_CYCLES, 4, idle cycles after each ack before next selection (>=1)
ACK_TIMEOUT, 1000, max cycles dispense_req may wait for ack

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse: begin dispensing change_amount
change_amount  in  8  amount to return, sampled on start
refill  in  1  pulse: reload all counters to INIT_CNT (IDLE only)
dispense_ack  in  1  actuator accepted current note
dispense_req  out  1  request to actuator
dispense_denom  out  5  one-hot {50,20,10,5,1}, valid while dispense_req
remaining  out  8  amount still owed
inventory  out  5*CNT_W  counters packed {c50,c20,c10,c5,c1}
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse: amount fully returned
fail  out  1  one-cycle pulse: aborted
fail_code  out  2  01 inventory exhausted, 10 ack timeout; holds until next start
state_out  out  7  one-hot state

Behaviour:
- Reset (sys_rst_n low, async): state IDLE; dispense_req 0, dispense_denom 0, remaining 0, done 0, fail 0, fail_code 00; all counters = INIT_CNT; timers 0.
- States (one-hot): IDLE 01H, SELECT 02H, REQ 04H, WAIT_ACK 08H, GAP 10H, DONE 20H, FAIL 40H.
- IDLE: start -> latch remaining=change_amount, clear fail_code, go SELECT next cycle. refill (no start) -> counters = INIT_CNT. start and refill together -> refill applied, start honoured. start/refill outside IDLE ignored.
- SELECT (1 cycle): remaining==0 -> DONE. Else pick largest d in {50,20,10,5,1} with d<=remaining and count_d>0; found -> latch one-hot denom, go REQ; none -> fail_code=01, FAIL.
- REQ (1 cycle): assert dispense_req, clear timeout counter, go WAIT_ACK.
- WAIT_ACK: dispense_req and dispense_denom held stable. ack -> remaining -= d, count_d -= 1, dispense_req drops next cycle, go GAP. Timeout counter increments each cycle without ack; reaching ACK_TIMEOUT -> drop req, fail_code=10, FAIL. Ack in the same cycle the timeout is reached counts as success.
- Ack outside WAIT_ACK ignored.
- GAP: wait GAP_CYCLES, then SELECT.
- DONE: done=1 for exactly one cycle, then IDLE. remaining is 0.
- FAIL: fail=1 for exactly one cycle, then IDLE. remaining retains the unpaid amount; partial dispenses are not undone.
- Arithmetic: remaining never underflows, because d<=remaining is guaranteed by SELECT. Counters never underflow, because count_d>0 is guaranteed.
- Latency: start to first dispense_req = 2 cycles. change_amount=0 -> done asserted 2 cycles after start.
- Reset mid-operation: immediate return to reset values, dispense_req drops asynchronously.

Test Plan:
- Full inventory, start with 37 -> denoms 20,10,5,1,1 in order, each after one ack; done pulse; remaining 0; c20=7, c10=7, c5=7, c1=6.
- Start with 0 -> no dispense_req; done 2 cycles after start; inventory unchanged.
- Preload c20=0 (via earlier transactions), start 40 -> 10,10,10,10; done.
- INIT_CNT=2; exhaust c1, then start 3 -> fail, fail_code 01, remaining 3, no req issued. Separately, start 3 with c1=2, c5=0 -> 1,1, then fail with remaining 1.
- ACK_TIMEOUT=16, never ack -> req high exactly 16 cycles in WAIT_ACK, then fail, fail_code 10, remaining unchanged.
- Assert sys_rst_n low during WAIT_ACK -> dispense_req 0 immediately, state IDLE, counters = INIT_CNT. Also check start/refill pulses while busy are ignored.
